stage_buf: RTL and testbench

Parametrised pipeline stage register that replaces the fixed-field inter-stage latches with a generic payload bus and a valid/ready handshake. It holds one instruction bundle between two pipeline stages (e.g. decode→execute), inserts NOP bubbles on flush, and, when compiled with a skid slot, decouples the upstream ready from the downstream ready so that back-pressure no longer forms a combinational path through the pipeline. The `stall[5:0]` vector is no longer needed; stalls are expressed as `dn_ready` low.

---
 rtl/stage_buf_pkg.sv | 34 +++
 rtl/stage_buf_if.sv | 23 ++
 rtl/stage_buf_ctrl.sv | 87 ++++++++
 rtl/stage_buf.sv | 69 ++++++
 tb/tb_stage_buf.sv | 124 ++++++++++++
 5 files changed

// File: rtl/stage_buf_pkg.sv
// Shared types for stage_buf: FSM state encodings, register load selects, default width.
// Build option: STAGE_BUF_SKID_EN adds the skid slot and the FULL state.
package stage_buf_pkg;

  localparam int StageBufDataW = 160;

  typedef enum logic [1:0] {
    StageEmpty = 2'd0,
    StageBusy  = 2'd1,
    StageFull  = 2'd2
  } stage_state_e;

  typedef enum logic [1:0] {
    MainHold = 2'd0,
    MainUp   = 2'd1,
    MainSkid = 2'd2,
    MainNop  = 2'd3
  } main_sel_e;

  typedef enum logic [1:0] {
    SkidHold = 2'd0,
    SkidUp   = 2'd1,
    SkidNop  = 2'd2
  } skid_sel_e;

  function automatic logic [1:0] occ_of(input stage_state_e s);
    case (s)
      StageBusy: occ_of = 2'd1;
      StageFull: occ_of = 2'd2;
      default:   occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus occupancy.
interface stage_buf_if import stage_buf_pkg::*; #(
  parameter int DATA_W = StageBufDataW
) ();
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic              dn_valid;
  logic              dn_ready;
  logic [DATA_W-1:0] dn_data;
  logic [1:0]        occ;

  // master: the environment around the stage; slave: the stage itself
  modport master (
    output up_valid, up_data, dn_ready,
    input  up_ready, dn_valid, dn_data, occ
  );

  modport slave (
    input  up_valid, up_data, dn_ready,
    output up_ready, dn_valid, dn_data, occ
  );
endinterface

// File: rtl/stage_buf_ctrl.sv
// stage_buf control: occupancy FSM, handshake outputs and data register load selects.
// Build option: STAGE_BUF_SKID_EN enables the FULL state and a state-derived up_ready.
module stage_buf_ctrl import stage_buf_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       up_valid,
  input  logic       dn_ready,
  output logic       up_ready,
  output logic       dn_valid,
  output logic [1:0] occ,
  output main_sel_e  main_sel
`ifdef STAGE_BUF_SKID_EN
  ,
  output skid_sel_e  skid_sel
`endif
);

  stage_state_e state, nxt;
  logic         up_x, dn_x;

  assign dn_valid = (state != StageEmpty);
  assign occ      = occ_of(state);

`ifdef STAGE_BUF_SKID_EN
  // Derived from the state register only: no path from dn_ready.
  assign up_ready = (state != StageFull);
`else
  assign up_ready = !dn_valid | dn_ready;
`endif

  assign up_x = up_valid & up_ready & !flush;
  assign dn_x = dn_valid & dn_ready;

  always_comb begin
    nxt      = state;
    main_sel = MainHold;
`ifdef STAGE_BUF_SKID_EN
    skid_sel = SkidHold;
`endif
    if (rst || flush) begin
      nxt      = StageEmpty;
      main_sel = MainNop;
`ifdef STAGE_BUF_SKID_EN
      skid_sel = SkidNop;
`endif
    end else begin
      case (state)
        StageEmpty: if (up_x) begin
          nxt      = StageBusy;
          main_sel = MainUp;
        end
        StageBusy: begin
          if (up_x && dn_x) begin
            main_sel = MainUp;
          end else if (dn_x) begin
            nxt      = StageEmpty;
            main_sel = MainNop;
          end
`ifdef STAGE_BUF_SKID_EN
          else if (up_x) begin
            nxt      = StageFull;
            skid_sel = SkidUp;
          end
`endif
        end
`ifdef STAGE_BUF_SKID_EN
        StageFull: if (dn_x) begin
          nxt      = StageBusy;
          main_sel = MainSkid;
          skid_sel = SkidNop;
        end
`endif
        default: begin
          nxt      = StageEmpty;
          main_sel = MainNop;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= StageEmpty;
    else     state <= nxt;
  end

endmodule

// File: rtl/stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush-to-NOP and optional skid slot.
// Build option: STAGE_BUF_SKID_EN adds the second (skid) entry.
module stage_buf import stage_buf_pkg::*; #(
  parameter int                DATA_W      = StageBufDataW,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  stage_buf_if.slave  bus
);

  main_sel_e         main_sel;
  logic [DATA_W-1:0] main_q;

`ifdef STAGE_BUF_SKID_EN
  skid_sel_e         skid_sel;
  logic [DATA_W-1:0] skid_q;
`endif

  stage_buf_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up_valid (bus.up_valid),
    .dn_ready (bus.dn_ready),
    .up_ready (bus.up_ready),
    .dn_valid (bus.dn_valid),
    .occ      (bus.occ),
    .main_sel (main_sel)
`ifdef STAGE_BUF_SKID_EN
    ,
    .skid_sel (skid_sel)
`endif
  );

  // main is cleared to NOP whenever the stage empties, so dn_data needs no output mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= NOP_PAYLOAD;
    end else begin
      case (main_sel)
        MainUp:   main_q <= bus.up_data;
`ifdef STAGE_BUF_SKID_EN
        MainSkid: main_q <= skid_q;
`endif
        MainNop:  main_q <= NOP_PAYLOAD;
        default:  main_q <= main_q;
      endcase
    end
  end

`ifdef STAGE_BUF_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= NOP_PAYLOAD;
    end else begin
      case (skid_sel)
        SkidUp:  skid_q <= bus.up_data;
        SkidNop: skid_q <= NOP_PAYLOAD;
        default: skid_q <= skid_q;
      endcase
    end
  end
`endif

  assign bus.dn_data = main_q;

endmodule

// File: tb/tb_stage_buf.sv
// Self-checking bench for stage_buf: directed steps then random valid/ready/flush/reset
// against a queue model of held bundles (capacity 2 with STAGE_BUF_SKID_EN, else 1).
module tb_stage_buf;
  import stage_buf_pkg::*;

  localparam int            DW  = StageBufDataW;
  localparam logic [DW-1:0] NOP = {20{8'h5A}};
`ifdef STAGE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  stage_buf_if #(.DATA_W(DW)) bus ();

  stage_buf #(.DATA_W(DW), .NOP_PAYLOAD(NOP)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_payload();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive, compare outputs mid-cycle against the model, advance the model at the edge.
  task automatic cycle(input string ph, input logic uv, input logic [DW-1:0] ud,
                       input logic dr, input logic fl, input logic rs);
    logic exp_ur, up_x, dn_x;
    int   n;
    bus.up_valid = uv;
    bus.up_data  = ud;
    bus.dn_ready = dr;
    flush        = fl;
    rst          = rs;
    @(negedge clk);
    n      = mq.size();
    exp_ur = SKID ? (n < 2) : (n == 0 || dr);
    check({ph, ".dn_valid"}, DW'(bus.dn_valid), DW'(n != 0));
    check({ph, ".dn_data"},  bus.dn_data, (n != 0) ? mq[0] : NOP);
    check({ph, ".occ"},      DW'(bus.occ), DW'(n));
    check({ph, ".up_ready"}, DW'(bus.up_ready), DW'(exp_ur));
    up_x = uv && exp_ur && !fl && !rs;
    dn_x = (n != 0) && dr && !rs;
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      if (dn_x) void'(mq.pop_front());
      if (up_x) mq.push_back(ud);
    end
    #1;
  endtask

  initial begin
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    bus.dn_ready = 1'b0;
    flush        = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;

    // reset values, with a handshake offered during reset
    cycle("rst_hold", 1'b1, DW'(32'h77), 1'b1, 1'b0, 1'b1);
    cycle("rst_val",  1'b0, '0, 1'b0, 1'b0, 1'b0);

    // stream 1..8 with dn_ready high, then drain
    for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("stream_idle",  1'b0, '0, 1'b1, 1'b0, 1'b0);

    // back-pressure: stall 3 cycles mid-stream, then release
    for (int i = 16; i < 20; i++) cycle("bp_pre", 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 20; i < 23; i++) cycle("bp_stall", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 23; i < 27; i++) cycle("bp_rel", 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)   cycle("bp_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush while holding A,B with C offered: C must never appear
    cycle("fl_a", 1'b1, DW'(32'hA), 1'b0, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, DW'(32'hB), 1'b0, 1'b0, 1'b0);
    cycle("fl_c", 1'b1, DW'(32'hC), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("fl_after", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // reset while full, with a handshake during reset
    cycle("rm_a", 1'b1, DW'(32'h11), 1'b0, 1'b0, 1'b0);
    cycle("rm_b", 1'b1, DW'(32'h22), 1'b0, 1'b0, 1'b0);
    cycle("rm_rst", 1'b1, DW'(32'h33), 1'b1, 1'b0, 1'b1);
    cycle("rm_after", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // single-entry back-pressure: up_ready follows dn_ready combinationally without skid
    cycle("nr_fill", 1'b1, DW'(32'h44), 1'b0, 1'b0, 1'b0);
    cycle("nr_stall", 1'b1, DW'(32'h55), 1'b0, 1'b0, 1'b0);
    cycle("nr_go", 1'b1, DW'(32'h66), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("nr_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // random traffic with rare flush and reset
    for (int i = 0; i < 10000; i++)
      cycle("rand", 1'($urandom_range(0, 1)), rnd_payload(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 255) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
